// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared types and constants for the 4:1 round-robin mux arbiter
//
// Purpose: arbiter state encoding, requester count, select width and a
//          select-to-one-hot helper shared by mux4_rr_arbiter and rr_pick.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant vector for a given mux select.
  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// rtl/mux4_rr_arbiter_rr_pick.sv - rotating-priority first-set-bit picker
//
// Purpose: finds the first asserted request scanning ptr, ptr+1, ptr+2, ptr+3
//          (wrapping modulo 4).
// Ports:
//   req_i   [3:0] request vector
//   ptr_i   [1:0] highest-priority slot for this scan
//   found_o       at least one request is set
//   idx_o   [1:0] index of the winning request (0 when none found)
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic             found_c;
  logic [SEL_W-1:0] idx_c;
  logic [SEL_W-1:0] cand;

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // SEL_W-bit addition wraps naturally, giving the modulo-4 scan order.
      cand = ptr_i + SEL_W'(i);
      if (!found_c && req_i[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

  assign found_o = found_c;
  assign idx_o   = idx_c;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin sequencer for a shared 4:1 data mux
//
// Purpose: grants one of four requesters at a time, steers the 4:1 data mux,
//          and hands beats to a single consumer over valid/ready. A grant lasts
//          at most HOLD_MAX transfers before priority rotates.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req  [3:0] per-requester request, held while that requester has data
//   d0..d3     requester data, WIDTH bits each
//   out_ready  consumer accepts the current beat
//   out_valid  beat present on out_data
//   out_data   selected data, zero whenever out_valid is low
//   sel  [1:0] registered mux select
//   grant[3:0] registered one-hot grant, 0000 when idle
//   ack  [3:0] one-hot pulse marking an accepted transfer
//   busy       arbiter is in GRANT
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy
);

  localparam int              CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   sel_next_slot;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WIDTH-1:0]   data_sel;

  // ---------------------------------------------------------------------------
  // Picker: when idle it scans from the stored pointer; while granted it scans
  // from the slot after the current select, so the pick is already the correct
  // answer for any leaving event this cycle.
  // ---------------------------------------------------------------------------
  assign sel_next_slot = sel_q + SEL_W'(1);
  assign pick_ptr      = (state_q == IDLE) ? ptr_q : sel_next_slot;

  rr_pick u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Handshake and datapath
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign xfer      = out_valid && out_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    data_sel = '0;
    case (sel_q)
      2'd0:    data_sel = d0;
      2'd1:    data_sel = d1;
      2'd2:    data_sel = d2;
      default: data_sel = d3;
    endcase
  end

  assign out_data = out_valid ? data_sel : '0;
  assign ack      = grant_q & {NUM_REQ{xfer}};
  assign sel      = sel_q;
  assign grant    = grant_q;
  assign busy     = (state_q == GRANT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = sel_onehot(pick_idx);
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (!out_valid) begin
          // Release: granted requester dropped its request; this cycle is the
          // bubble and the grant moves on (or the arbiter idles).
          ptr_d = sel_next_slot;
          cnt_d = '0;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = sel_onehot(pick_idx);
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (xfer) begin
          if (cnt_inc == CNT_LAST) begin
            // Forced rotation: req[sel] is still high so the pick always
            // succeeds, landing back on sel only when nobody else asks.
            ptr_d   = sel_next_slot;
            sel_d   = pick_idx;
            grant_d = sel_onehot(pick_idx);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // Backpressure (valid, not ready): everything holds.
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard testbench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  bit         clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] sel;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       busy;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   xfer_cnt;
  int   t;
  logic [3:0] dtab [4];

  mux4_rr_arbiter #(.WIDTH(4), .HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .grant     (grant),
    .ack       (ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [3:0] data);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_xfers(input int n, output int ticks);
    int target;
    target = xfer_cnt + n;
    ticks  = 0;
    while (xfer_cnt < target && ticks < 200) begin
      tick();
      ticks++;
    end
    check("xfer_timeout", 32'(xfer_cnt >= target), 1);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data,  0);
    check({tag, "_grant"}, grant,     0);
    check({tag, "_sel"},   sel,       0);
    check({tag, "_ack"},   ack,       0);
    check({tag, "_busy"},  busy,      0);
  endtask

  // Monitor: pops one expected beat per accepted transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_data", out_data, mon_e.data);
          check("xfer_ack",  ack,      32'(1) << mon_e.idx);
          check("xfer_sel",  sel,      mon_e.idx);
        end
      end else begin
        check("no_xfer_ack", ack, 0);
        if (!out_valid) check("gated_data", out_data, 0);
      end
    end
  end

  initial begin
    dtab[0] = 4'b1110; dtab[1] = 4'b1010; dtab[2] = 4'b1011; dtab[3] = 4'b0010;
    rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
    d0 = dtab[0]; d1 = dtab[1]; d2 = dtab[2]; d3 = dtab[3];

    // Reset state with requests pending, before any clock edge.
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("first_grant", grant, 4'b0001);
    check("first_sel",   sel,   0);
    check("first_busy",  busy,  1);
    check("first_valid", out_valid, 1);
    check("first_data",  out_data, 4'b1110);
    req = 4'b0000;
    rst_pulse();

    // Single requester: forced rotation regrants with no gap.
    for (int i = 0; i < 6; i++) push(2, 4'b1011);
    req = 4'b0100; out_ready = 1'b1;
    wait_xfers(6, t);
    check("single_no_gap_ticks", t, 7);
    req = 4'b0000;
    tick();
    check("single_idle_busy",  busy,  0);
    check("single_idle_grant", grant, 0);
    rst_pulse();

    // Round robin over all four.
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 4; b++) push(r % 4, dtab[r % 4]);
    req = 4'b1111;
    wait_xfers(20, t);
    check("rr_ticks", t, 21);
    req = 4'b0000;
    tick();
    check("rr_idle_busy", busy, 0);
    rst_pulse();

    // Backpressure: beat count frozen, so exactly two more beats after resume.
    for (int b = 0; b < 4; b++) push(1, 4'b1010);
    for (int b = 0; b < 4; b++) push(3, 4'b0010);
    req = 4'b1010;
    wait_xfers(2, t);
    out_ready = 1'b0;
    repeat (10) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data,  4'b1010);
      check("bp_ack",   ack,       0);
      check("bp_grant", grant,     4'b0010);
      tick();
    end
    out_ready = 1'b1;
    wait_xfers(6, t);
    check("bp_resume_ticks", t, 6);
    req = 4'b0000;
    tick();
    check("bp_idle_busy", busy, 0);
    rst_pulse();

    // Release: requester 1 drops after two beats, requester 3 takes over.
    push(1, 4'b1010); push(1, 4'b1010);
    push(3, 4'b0010); push(3, 4'b0010);
    req = 4'b1010;
    wait_xfers(2, t);
    req = 4'b1000;
    #1;
    check("rel_bubble", out_valid, 0);
    tick();
    check("rel_grant", grant, 4'b1000);
    check("rel_sel",   sel,   3);
    wait_xfers(2, t);
    req = 4'b0000;
    #1;
    check("rel2_bubble", out_valid, 0);
    tick();
    check("rel_idle_busy", busy, 0);
    req = 4'b1010; out_ready = 1'b0;
    tick();
    check("rel_ptr_wrap_grant", grant, 4'b0010);
    req = 4'b0000; out_ready = 1'b1;
    tick();
    rst_pulse();

    // Async reset during beat 2 of requester 2.
    push(2, 4'b1011);
    req = 4'b0100; out_ready = 1'b1;
    wait_xfers(1, t);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async");
    req = 4'b1111; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_grant", grant, 4'b0001);
    check("post_reset_sel",   sel,   0);

    rst = 1'b1;
    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
